conv77_line_feeder: RTL and testbench
=====================================

# conv77_line_feeder

Raster-to-column feeder for the 7x7 convolution window. It accepts one pixel per cycle from a raster-order stream and buffers the previous six image rows in line memories. Each accepted pixel produces one 7-pixel vertical column plus the shift enable that drives the convolution window's `en`/`in1..in7` inputs. It also flags the cycles on which the window holds a complete in-image 7x7 neighbourhood.

## Interface
- `BIT_WIDTH`, 8: pixel width.
- `IMG_WIDTH`, 28: pixels per row, ≥ 7.
- `IMG_HEIGHT`, 28: rows per frame, ≥ 7.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pix_valid`  in  1  input pixel present.
- `pix_ready`  out  1  feeder can accept; equals `!hold`.
- `pix_in`  in  BIT_WIDTH  signed pixel, raster order.
- `hold`  in  1  downstream stall; no accept, no shift while high.
- `col_en`  out  1  one-cycle pulse; drives the window `en`.
- `col1`..`col7`  out  BIT_WIDTH each  column; `col1` is the oldest row (r-6), `col7` is the current row r. These drive `in1..in7`, sign-extended at instantiation.
- `win_valid`  out  1  window is full and in-image; coincident with `col_en`.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame.

## Operation
- Accept occurs when `pix_valid && pix_ready`.
- Counters: `c` runs 0..IMG_WIDTH-1 and `r` runs 0..IMG_HEIGHT-1. Both advance only on accept.
  - When `c == IMG_WIDTH-1`: `c` goes to 0 and `r` increments.
  - On the final pixel (`r == IMG_HEIGHT-1`, `c == IMG_WIDTH-1`): both go to 0 and `frame_done` pulses.
- Line memory is six banks `mem[0..5]`, each IMG_WIDTH x BIT_WIDTH. On accept at column `c`:
  - Read `mem[0..5][c]` before write.
  - Write `mem[k][c] <= mem[k+1][c]` for k = 0..4, and `mem[5][c] <= pix_in`.
- Registered outputs on accept: `col1..col6 <= mem[0..5][c]`, `col7 <= pix_in`, `col_en <= 1`.
- `win_valid <= (r >= 6) && (c >= 6)` evaluated on the accepted pixel's coordinates. Once the window has shifted, it then holds rows r-6..r and columns c-6..c.
- With no accept, `col_en`, `win_valid` and `frame_done` are 0. `col1..col7` hold their last values.
- Memories are not cleared at frame boundaries or on reset. Unwritten data is undefined at power-up.
- Reset (asynchronous, active-low):
  - `r`, `c` go to 0.
  - `col_en`, `win_valid`, `frame_done` and `col1..col7` go to 0.
  - `pix_ready` follows `!hold` combinationally.
  - Reset mid-frame abandons the frame. The next accepted pixel is (0,0).

## Timing
- Latency is 1 cycle from accept to `col_en` and column.
- Throughput is one pixel per cycle.
- `hold` rising in the same cycle as `pix_valid` blocks the accept: no counter move, no pulse.
- `frame_done` is asserted in the same cycle as the `col_en` of the last pixel.
- Back-to-back frames need no gap. Pixel (0,0) of the next frame may be accepted in the cycle after the last pixel.
- Windows per frame: (IMG_WIDTH-6)·(IMG_HEIGHT-6).

## Configuration
- `CONV77_FEEDER_ZFILL_EN` defined:
  - `colk` (k = 1..6) outputs 0 whenever its source row `r-7+k < 0` in the current frame.
  - Stale previous-frame or power-up data never appears.
  - `win_valid` is unchanged.
- Undefined: `col1..col6` output raw memory contents.

## Test plan
Bench uses IMG_WIDTH = IMG_HEIGHT = 8 and `pix_in = 8r + c`, with `pix_valid` continuous.

1. Single frame. At pixel (6,6), value 54, the next cycle shows `col1..col7` = 6, 14, 22, 30, 38, 46, 54 with `col_en = win_valid = 1`. Exactly 4 `win_valid` pulses occur, at (6,6), (6,7), (7,6), (7,7).
2. `frame_done` pulses exactly once, in the cycle after pixel (7,7) is accepted. The next frame's first pixel yields `win_valid = 0`.
3. `hold` asserted for 3 cycles at (6,3). `pix_ready = 0` and there are no `col_en` pulses. After release, (6,3) gives `col7 = 51`, `col1 = 3`, and the sequence is unbroken.
4. Second frame at (0,3):
   - Without the macro: `col6 = 59` (previous row 7) and `col1 = 19`.
   - With `CONV77_FEEDER_ZFILL_EN`: `col1..col6 = 0` and `col7 = 3`.
5. Reset pulsed mid-frame at (4,5):
   - All outputs go to 0 asynchronously.
   - After release, the frame is restarted from (0,0) and the first `win_valid` is at (6,6) with `col7 = 54`.
6. `pix_valid` toggled 1/0 every cycle. `col_en` pulses every other cycle and column values match scenario 1.

Source files
------------

// File: rtl/conv77_line_feeder_if.sv
// Pixel-in / column-out bundle between a raster source and the 7x7 column feeder.
interface conv77_line_feeder_if #(
  parameter int BIT_WIDTH = 8
);
  logic                        pix_valid;
  logic                        pix_ready;
  logic signed [BIT_WIDTH-1:0] pix_in;
  logic                        hold;
  logic                        col_en;
  logic signed [BIT_WIDTH-1:0] col1;
  logic signed [BIT_WIDTH-1:0] col2;
  logic signed [BIT_WIDTH-1:0] col3;
  logic signed [BIT_WIDTH-1:0] col4;
  logic signed [BIT_WIDTH-1:0] col5;
  logic signed [BIT_WIDTH-1:0] col6;
  logic signed [BIT_WIDTH-1:0] col7;
  logic                        win_valid;
  logic                        frame_done;

  modport master (
    output pix_valid, pix_in, hold,
    input  pix_ready, col_en, col1, col2, col3, col4, col5, col6, col7,
           win_valid, frame_done
  );

  modport slave (
    input  pix_valid, pix_in, hold,
    output pix_ready, col_en, col1, col2, col3, col4, col5, col6, col7,
           win_valid, frame_done
  );
endinterface

// File: rtl/conv77_line_feeder.sv
// Raster-to-column feeder for a 7x7 convolution window: six line banks plus the live pixel.
// Optional CONV77_FEEDER_ZFILL_EN zeroes column taps whose source row lies above the frame.
module conv77_line_feeder #(
  parameter int BIT_WIDTH  = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv77_line_feeder_if.slave   bus
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic          accept;
  logic          last_col;
  logic          last_pix;

  logic [BIT_WIDTH-1:0] rd_data [6];
  logic [BIT_WIDTH-1:0] wr_data [6];
  logic [BIT_WIDTH-1:0] col_q   [7];
  logic                 col_en_q;
  logic                 win_valid_q;
  logic                 frame_done_q;

  assign bus.pix_ready = !bus.hold;
  assign accept        = bus.pix_valid && !bus.hold;
  assign last_col      = (c_q == CW'(IMG_WIDTH - 1));
  assign last_pix      = last_col && (r_q == RW'(IMG_HEIGHT - 1));

  always_comb begin
    c_d = c_q;
    r_d = r_q;
    if (accept) begin
      if (last_col) begin
        c_d = '0;
        r_d = last_pix ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Each column address is a 6-deep shift chain across the banks: read all, shift up, insert pixel.
  for (genvar gi = 0; gi < 6; gi++) begin : g_bank
    logic [BIT_WIDTH-1:0] mem_q [IMG_WIDTH];

    assign rd_data[gi] = mem_q[c_q];

    if (gi == 5) begin : g_top
      assign wr_data[gi] = bus.pix_in;
    end else begin : g_mid
      assign wr_data[gi] = rd_data[gi+1];
    end

    always_ff @(posedge clk) begin
      if (accept) begin
        mem_q[c_q] <= wr_data[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q          <= '0;
      r_q          <= '0;
      col_en_q     <= 1'b0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 7; k++) begin
        col_q[k] <= '0;
      end
    end else begin
      c_q          <= c_d;
      r_q          <= r_d;
      col_en_q     <= accept;
      win_valid_q  <= accept && (r_q >= RW'(6)) && (c_q >= CW'(6));
      frame_done_q <= accept && last_pix;
      if (accept) begin
        for (int k = 0; k < 6; k++) begin
`ifdef CONV77_FEEDER_ZFILL_EN
          // Tap k sources row r-6+k; rows above the frame top read as zero.
          col_q[k] <= (int'(r_q) < 6 - k) ? '0 : rd_data[k];
`else
          col_q[k] <= rd_data[k];
`endif
        end
        col_q[6] <= bus.pix_in;
      end
    end
  end

  assign bus.col_en     = col_en_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.col1       = col_q[0];
  assign bus.col2       = col_q[1];
  assign bus.col3       = col_q[2];
  assign bus.col4       = col_q[3];
  assign bus.col5       = col_q[4];
  assign bus.col6       = col_q[5];
  assign bus.col7       = col_q[6];
endmodule

// File: tb/tb_conv77_line_feeder.sv
// Self-checking bench for conv77_line_feeder on an 8x8 image with pixel value 8r+c.
module tb_conv77_line_feeder;
  localparam int BW = 8;
  localparam int W  = 8;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv77_line_feeder_if #(.BIT_WIDTH(BW)) bus ();

  conv77_line_feeder #(.BIT_WIDTH(BW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-column history of every accepted pixel (line memory is never cleared).
  int         mr, mc;
  int         hist [W][$];
  logic [7:0] e_col   [1:7];
  bit         e_known [1:7];
  bit         e_en, e_win, e_fd;
  bit         acc;
  int         acc_r, acc_c;

  typedef struct {
    int         r;
    int         c;
    logic [7:0] cols [1:7];
    bit         win;
  } spot_t;
  spot_t tbl [6];

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] get_col(int k);
    case (k)
      1: return bus.col1;
      2: return bus.col2;
      3: return bus.col3;
      4: return bus.col4;
      5: return bus.col5;
      6: return bus.col6;
      default: return bus.col7;
    endcase
  endfunction

  function automatic void model_reset();
    mr = 0; mc = 0;
    e_en = 0; e_win = 0; e_fd = 0;
    for (int k = 1; k <= 7; k++) begin
      e_col[k] = '0;
      e_known[k] = 1;
    end
  endfunction

  function automatic void model_accept(logic [7:0] px);
    int n;
    n = hist[mc].size();
    for (int k = 1; k <= 6; k++) begin
      int depth;
      depth = 7 - k;
`ifdef CONV77_FEEDER_ZFILL_EN
      if (mr < depth) begin
        e_col[k] = '0; e_known[k] = 1;
      end else
`endif
      if (n >= depth) begin
        e_col[k] = 8'(hist[mc][n - depth]); e_known[k] = 1;
      end else begin
        e_known[k] = 0;
      end
    end
    e_col[7] = px; e_known[7] = 1;
    e_en  = 1;
    e_win = (mr >= 6) && (mc >= 6);
    e_fd  = (mr == H - 1) && (mc == W - 1);
    hist[mc].push_back(int'(px));
    acc_r = mr; acc_c = mc;
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endfunction

  task automatic step(input logic v, input logic h, input logic [7:0] px);
    bus.pix_valid = v;
    bus.hold      = h;
    bus.pix_in    = px;
    #1;
    chk("pix_ready", int'(bus.pix_ready), int'(!h));
    @(posedge clk);
    acc = v && !h;
    if (acc) model_accept(px);
    else begin
      e_en = 0; e_win = 0; e_fd = 0;
    end
    #1;
    chk("col_en", int'(bus.col_en), int'(e_en));
    chk("win_valid", int'(bus.win_valid), int'(e_win));
    chk("frame_done", int'(bus.frame_done), int'(e_fd));
    for (int k = 1; k <= 7; k++)
      if (e_known[k]) chk($sformatf("col%0d", k), int'(get_col(k)), int'(e_col[k]));
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_col_en"}, int'(bus.col_en), 0);
    chk({tag, "_win_valid"}, int'(bus.win_valid), 0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
    for (int k = 1; k <= 7; k++) chk($sformatf("%s_col%0d", tag, k), int'(get_col(k)), 0);
  endtask

  function automatic void set_spot(int i, int r, int c, bit win);
    tbl[i].r = r; tbl[i].c = c; tbl[i].win = win;
    for (int k = 1; k <= 7; k++) tbl[i].cols[k] = 8'(8 * (r - 7 + k) + c);
  endfunction

  initial begin
    int ti, wins, fds;
    bit first_seen;

    set_spot(0, 6, 3, 0);
    set_spot(1, 6, 5, 0);
    set_spot(2, 6, 6, 1);
    set_spot(3, 6, 7, 1);
    set_spot(4, 7, 6, 1);
    set_spot(5, 7, 7, 1);

    bus.pix_valid = 0; bus.hold = 0; bus.pix_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1 with a 3-cycle hold at (6,3); spot table checked as pixels arrive.
    ti = 0; wins = 0; fds = 0;
    for (int p = 0; p < W * H; p++) begin
      if (mr == 6 && mc == 3) begin
        for (int j = 0; j < 3; j++) begin
          step(1, 1, 8'(8 * mr + mc));
          chk("hold_no_en", int'(bus.col_en), 0);
        end
      end
      step(1, 0, 8'(8 * mr + mc));
      if (bus.win_valid) wins++;
      if (bus.frame_done) fds++;
      if (ti < 6 && acc && acc_r == tbl[ti].r && acc_c == tbl[ti].c) begin
        for (int k = 1; k <= 7; k++)
          chk($sformatf("spot_r%0dc%0d_col%0d", tbl[ti].r, tbl[ti].c, k),
              int'(get_col(k)), int'(tbl[ti].cols[k]));
        chk($sformatf("spot_r%0dc%0d_win", tbl[ti].r, tbl[ti].c), int'(bus.win_valid), int'(tbl[ti].win));
        ti++;
      end
    end
    chk("frame1_win_count", wins, 4);
    chk("frame1_done_count", fds, 1);
    chk("spot_table_hits", ti, 6);

    // Frame 2 starts without a gap; stop just after accepting (4,5).
    step(1, 0, 8'(0));
    chk("frame2_first_win", int'(bus.win_valid), 0);
    chk("frame2_first_en", int'(bus.col_en), 1);
    for (int p = 1; p < W * H; p++) begin
      step(1, 0, 8'(8 * mr + mc));
      if (acc && acc_r == 0 && acc_c == 3) begin
`ifdef CONV77_FEEDER_ZFILL_EN
        for (int k = 1; k <= 6; k++) chk($sformatf("zfill_col%0d", k), int'(get_col(k)), 0);
`else
        chk("f2_col6", int'(bus.col6), 59);
        chk("f2_col1", int'(bus.col1), 19);
`endif
        chk("f2_col7", int'(bus.col7), 3);
      end
      if (acc && acc_r == 4 && acc_c == 5) break;
    end
    chk("pre_reset_en", int'(bus.col_en), 1);

    // Asynchronous mid-cycle reset.
    bus.pix_valid = 0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    first_seen = 0;
    for (int p = 0; p < W * H; p++) begin
      step(1, 0, 8'(8 * mr + mc));
      if (bus.win_valid && !first_seen) begin
        first_seen = 1;
        chk("restart_first_win_r", acc_r, 6);
        chk("restart_first_win_c", acc_c, 6);
        chk("restart_first_win_col7", int'(bus.col7), 54);
      end
    end
    chk("restart_win_seen", int'(first_seen), 1);

    // pix_valid toggling every cycle.
    for (int i = 0; i < 2 * W * H; i++) begin
      step((i % 2) == 0, 0, 8'(8 * mr + mc));
      chk("toggle_en", int'(bus.col_en), int'((i % 2) == 0));
    end

    // Randomised valid/hold/data against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
